// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Purpose:
//   Parallel-to-serial stage that sits after the parallel register. It takes
//   the registered word through a load/ready handshake. It then shifts the
//   word out one bit per external shift_en tick. A one-cycle frame_done pulse
//   marks the end of each frame.
//
// Parameters:
//   DATA_WIDTH : width of the parallel word (2..32)
//   MSB_FIRST  : 0 = shift LSB first, 1 = shift MSB first
//
// Ports:
//   Clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   D          in   parallel word from the upstream register
//   load_valid in   upstream has a word on D
//   load_ready out  stage is idle and accepts a word this cycle
//   shift_en   in   bit-advance tick
//   sout       out  serial data bit (idles high)
//   sout_valid out  sout carries a frame bit
//   frame_done out  one-cycle pulse after the last bit is consumed
//   bit_cnt    out  index of the bit currently on sout
//
// Optional feature:
//   SHIFT_SERIALIZER_PARITY_EN: when defined, the stage latches an even-parity
//   bit (^D) at accept. It sends that bit as an extra final frame bit.
// -----------------------------------------------------------------------------
module shift_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                            Clk,
  input  logic                            reset_n,
  input  logic [DATA_WIDTH-1:0]           D,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic                            shift_en,
  output logic                            sout,
  output logic                            sout_valid,
  output logic                            frame_done,
  output logic [$clog2(DATA_WIDTH+2)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shifted;
  logic                  tx_bit;
  logic                  accept;
  logic                  advance;

  assign accept  = (state == IDLE) && load_valid;
  assign advance = (state == SHIFT) && shift_en && (bit_cnt != LAST_IDX);

  // Shift toward the output end and zero-fill the vacated bit.
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg[DATA_WIDTH-1:1]};

`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic parity;

  // Parity is taken from the word as captured, so later D changes do not matter.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      parity <= 1'b0;
    else if (accept)
      parity <= ^D;
  end

  // After the data bits have gone out, the counter reaches DATA_WIDTH.
  // The parity bit is sent in that final slot.
  assign tx_bit = (bit_cnt == CNT_W'(DATA_WIDTH)) ? parity
                : ((MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0]);
`else
  assign tx_bit = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
`endif

  // State register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and output decode. The outputs come only from
  // registered state, so no input reaches an output combinationally.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    sout       = 1'b1;
    sout_valid = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid)
          next_state = SHIFT;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = tx_bit;
        if (shift_en && (bit_cnt == LAST_IDX))
          next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift register and bit counter. The counter is not stepped on the final
  // tick, so it still holds FRAME_LEN-1 while the stage is in DONE.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= D;
      bit_cnt <= '0;
    end else if (advance) begin
      shreg   <= shreg_shifted;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_shift_serializer
//
// Self-checking bench for shift_serializer. It drives two instances from the
// same inputs: one shifts LSB first and one shifts MSB first. For each frame,
// the expected bit sequence comes straight from the data word, using the
// serializer's framing rules. The bench honours SHIFT_SERIALIZER_PARITY_EN
// when it is defined.
// -----------------------------------------------------------------------------
module tb_shift_serializer;

  localparam int W = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam int CW = $clog2(W + 2);

  logic          Clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  D;
  logic          load_valid;
  logic          shift_en;

  logic          lr_l, so_l, sv_l, fd_l;
  logic [CW-1:0] bc_l;
  logic          lr_m, so_m, sv_m, fd_m;
  logic [CW-1:0] bc_m;

  int checks   = 0;
  int failures = 0;

  // 100 MHz-style free-running clock.
  always #5 Clk = ~Clk;

  shift_serializer #(.DATA_WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .Clk(Clk), .reset_n(reset_n), .D(D), .load_valid(load_valid),
    .load_ready(lr_l), .shift_en(shift_en), .sout(so_l),
    .sout_valid(sv_l), .frame_done(fd_l), .bit_cnt(bc_l)
  );

  shift_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .Clk(Clk), .reset_n(reset_n), .D(D), .load_valid(load_valid),
    .load_ready(lr_m), .shift_en(shift_en), .sout(so_m),
    .sout_valid(sv_m), .frame_done(fd_m), .bit_cnt(bc_m)
  );

  // Single comparison point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i of word w. Data bits come first, in the chosen order.
  // In the parity build, the even parity of the word follows them.
  function automatic logic expBit(input logic [W-1:0] w, input int i,
                                  input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkIdle(input string where);
    checkOutput({where, ".lsb.load_ready"}, 32'(lr_l), 32'd1);
    checkOutput({where, ".lsb.sout"},       32'(so_l), 32'd1);
    checkOutput({where, ".lsb.sout_valid"}, 32'(sv_l), 32'd0);
    checkOutput({where, ".lsb.frame_done"}, 32'(fd_l), 32'd0);
    checkOutput({where, ".msb.load_ready"}, 32'(lr_m), 32'd1);
    checkOutput({where, ".msb.sout"},       32'(so_m), 32'd1);
    checkOutput({where, ".msb.sout_valid"}, 32'(sv_m), 32'd0);
    checkOutput({where, ".msb.frame_done"}, 32'(fd_m), 32'd0);
  endtask

  task automatic checkReset(input string where);
    checkIdle(where);
    checkOutput({where, ".lsb.bit_cnt"}, 32'(bc_l), 32'd0);
    checkOutput({where, ".msb.bit_cnt"}, 32'(bc_m), 32'd0);
  endtask

  task automatic checkShift(input string where, input logic [W-1:0] w,
                            input int i);
    checkOutput({where, ".lsb.sout"},       32'(so_l), 32'(expBit(w, i, 1'b0)));
    checkOutput({where, ".lsb.sout_valid"}, 32'(sv_l), 32'd1);
    checkOutput({where, ".lsb.load_ready"}, 32'(lr_l), 32'd0);
    checkOutput({where, ".lsb.frame_done"}, 32'(fd_l), 32'd0);
    checkOutput({where, ".lsb.bit_cnt"},    32'(bc_l), 32'(i));
    checkOutput({where, ".msb.sout"},       32'(so_m), 32'(expBit(w, i, 1'b1)));
    checkOutput({where, ".msb.sout_valid"}, 32'(sv_m), 32'd1);
    checkOutput({where, ".msb.load_ready"}, 32'(lr_m), 32'd0);
    checkOutput({where, ".msb.frame_done"}, 32'(fd_m), 32'd0);
    checkOutput({where, ".msb.bit_cnt"},    32'(bc_m), 32'(i));
  endtask

  task automatic checkDone(input string where);
    checkOutput({where, ".lsb.frame_done"}, 32'(fd_l), 32'd1);
    checkOutput({where, ".lsb.sout_valid"}, 32'(sv_l), 32'd0);
    checkOutput({where, ".lsb.sout"},       32'(so_l), 32'd1);
    checkOutput({where, ".lsb.load_ready"}, 32'(lr_l), 32'd0);
    checkOutput({where, ".lsb.bit_cnt"},    32'(bc_l), 32'(FL - 1));
    checkOutput({where, ".msb.frame_done"}, 32'(fd_m), 32'd1);
    checkOutput({where, ".msb.sout_valid"}, 32'(sv_m), 32'd0);
    checkOutput({where, ".msb.sout"},       32'(so_m), 32'd1);
    checkOutput({where, ".msb.load_ready"}, 32'(lr_m), 32'd0);
    checkOutput({where, ".msb.bit_cnt"},    32'(bc_m), 32'(FL - 1));
  endtask

  // Send one frame of word w.
  //   gap        : idle cycles before each tick (negative = random 0..3)
  //   busy       : hold load_valid high with D=FF for the whole frame
  //   abortAfter : when >= 0, assert reset after that many ticks
  // The task is entered and left just after a clock edge, with the DUT idle.
  task automatic applyStimulus(input logic [W-1:0] w, input int gap,
                               input bit busy, input int abortAfter);
    int g;
    D          = w;
    load_valid = 1'b1;
    shift_en   = 1'($urandom_range(0, 1));
    step();
    if (busy) begin
      load_valid = 1'b1;
      D          = '1;
    end else begin
      load_valid = 1'($urandom_range(0, 1));
      D          = W'($urandom);
    end
    for (int i = 0; i < FL; i++) begin
      checkShift("shift", w, i);
      if (abortAfter == i) begin
        #3 reset_n = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        #1 checkReset("abort");
        #2 reset_n = 1'b1;
        step();
        checkReset("post_abort");
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        shift_en = 1'b0;
        step();
        checkShift("hold", w, i);
      end
      shift_en = 1'b1;
      step();
    end
    checkDone("done");
    shift_en   = 1'($urandom_range(0, 1));
    load_valid = 1'($urandom_range(0, 1));
    D          = W'($urandom);
    step();
    checkIdle("after_done");
    load_valid = 1'b0;
    shift_en   = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    D          = '0;

    // The reset values must appear before any clock edge has occurred.
    #3 checkReset("reset_noclk");
    step();
    step();
    #3 reset_n = 1'b1;
    step();
    checkReset("reset_release");

    // Reset asserted in the middle of a cycle while the stage is idle.
    #3 reset_n = 1'b0;
    #1 checkReset("reset_midcycle");
    #2 reset_n = 1'b1;
    step();

    applyStimulus(8'hA5, 0, 1'b0, -1);
    applyStimulus(8'hA5, 3, 1'b0, -1);
    applyStimulus(8'h3C, -1, 1'b1, -1);
    applyStimulus(8'hA5, 0, 1'b0, 3);
    applyStimulus(8'h01, -1, 1'b0, -1);
    applyStimulus(8'h07, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        shift_en   = 1'($urandom_range(0, 1));
        D          = W'($urandom);
        step();
        checkIdle("idle_ignore");
      end
      applyStimulus(W'($urandom), -1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FL - 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
